// File: rtl/fb_bank_arbiter_pkg.sv
// Shared constants and types for the frame-buffer bank arbiter.
// The pixel address is a half-screen {row, col} index into one bank.
package fb_bank_arbiter_pkg;

  localparam int NUM_COLS = 64;
  localparam int NUM_ROWS = 64;

  // Two 12bpp pixels share one word, so one bank holds half the screen.
  localparam int DEF_ADDR_W       = $clog2(NUM_COLS) + $clog2(NUM_ROWS) - 1;
  localparam int DEF_DATA_W       = 24;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } swap_state_e;

endpackage

// File: rtl/fb_bank_arbiter_if.sv
// Bus bundle between the scan controller, host writer, RAM and the arbiter.
// The arbiter takes the slave view; the environment takes the master view.
interface fb_bank_arbiter_if #(
  parameter int ADDR_W = fb_bank_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = fb_bank_arbiter_pkg::DEF_DATA_W
);

  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  logic              frame_end;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              swap_req;
  logic              swap_done;
  logic              front_bank;
  logic              starve_err;

  logic [ADDR_W:0]   mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  scan_req, scan_addr, frame_end,
    input  wr_valid, wr_addr, wr_data, swap_req,
    input  mem_rdata,
    output scan_data, scan_valid, wr_ready,
    output swap_done, front_bank, starve_err,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output scan_req, scan_addr, frame_end,
    output wr_valid, wr_addr, wr_data, swap_req,
    output mem_rdata,
    input  scan_data, scan_valid, wr_ready,
    input  swap_done, front_bank, starve_err,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fb_bank_arbiter_wr_buf.sv
// One-entry valid/ready holding register for host pixel writes.
// Accepts only when empty and not held; empties on an external drain strobe.
module fb_wr_buf #(
  parameter int ADDR_W = fb_bank_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = fb_bank_arbiter_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_hold,
  input  logic              i_drain,
  output logic              o_buf_full,
  output logic [ADDR_W-1:0] o_buf_addr,
  output logic [DATA_W-1:0] o_buf_data
);

  logic              r_full;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;

  assign o_wr_ready = ~r_full & ~i_hold;
  assign w_accept   = i_wr_valid & o_wr_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_full <= 1'b1;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; r_full alone says whether they mean anything.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr <= i_wr_addr;
      r_data <= i_wr_data;
    end
  end

  assign o_buf_full = r_full;
  assign o_buf_addr = r_addr;
  assign o_buf_data = r_data;

endmodule

// File: rtl/fb_bank_arbiter.sv
// Double-buffered pixel RAM arbiter: scan reads always win, host writes drain
// from a one-entry buffer into the back bank, banks swap only at frame end.
module fb_bank_arbiter
  import fb_bank_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic               clk,
  input  logic               rst,
  fb_bank_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  swap_state_e       r_state;
  logic              r_front;
  logic              r_swap_done;
  logic              r_scan_valid;
  logic              r_starve_err;
  logic [CNT_W-1:0]  r_starve_cnt;

  logic              w_wr_ready;
  logic              w_buf_full;
  logic [ADDR_W-1:0] w_buf_addr;
  logic [DATA_W-1:0] w_buf_data;
  logic              w_swap_pend;
  logic              w_drain;
  logic              w_blocked;
  logic [ADDR_W:0]   w_mem_addr;
  logic              w_mem_we;

  assign w_swap_pend = (r_state == ST_PEND);
  // Gating with rst keeps a held write off the RAM while reset is asserted.
  assign w_drain     = rst & w_buf_full & ~bus.scan_req;
  assign w_blocked   = w_buf_full & bus.scan_req;

  fb_wr_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_buf (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (bus.wr_valid),
    .o_wr_ready (w_wr_ready),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .i_hold     (w_swap_pend | ~rst),
    .i_drain    (w_drain),
    .o_buf_full (w_buf_full),
    .o_buf_addr (w_buf_addr),
    .o_buf_data (w_buf_data)
  );

  // A pending swap waits for a frame end with the buffer empty, so the
  // back bank is complete when it becomes visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_front     <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (bus.swap_req) r_state <= ST_PEND;
        end
        ST_PEND: begin
          if (bus.frame_end && !w_buf_full) begin
            r_state     <= ST_RUN;
            r_front     <= ~r_front;
            r_swap_done <= 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
      r_starve_err <= 1'b0;
    end else begin
      if (w_drain) begin
        r_starve_cnt <= '0;
      end else if (w_blocked && (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
      if (w_blocked && (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1))) begin
        r_starve_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scan_valid <= 1'b0;
    end else begin
      r_scan_valid <= bus.scan_req;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_mem_addr = {r_front, bus.scan_addr};
    w_mem_we   = 1'b0;
    if (w_drain) begin
      w_mem_addr = {~r_front, w_buf_addr};
      w_mem_we   = 1'b1;
    end
  end

  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_wdata  = w_buf_data;
  assign bus.scan_data  = bus.mem_rdata;
  assign bus.scan_valid = r_scan_valid;
  assign bus.wr_ready   = w_wr_ready;
  assign bus.swap_done  = r_swap_done;
  assign bus.front_bank = r_front;
  assign bus.starve_err = r_starve_err;

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// Directed bench for fb_bank_arbiter: a cycle table of inputs and expected
// outputs, plus hand sequences for reset entry and write throughput.
module tb_fb_bank_arbiter;
  import fb_bank_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fb_bank_arbiter_if bus ();

  fb_bank_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port synchronous RAM model with a backdoor preload port.
  bit   [23:0] ram [4096];
  logic        pl_we   = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [23:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        sreq;
    logic [10:0] saddr;
    logic        wv;
    logic [10:0] waddr;
    logic [23:0] wdata;
    logic        swreq;
    logic        fe;
    logic        ready;
    logic        we;
    logic [11:0] addr;
    logic [23:0] ewdata;
    logic        svalid;
    logic [23:0] sdata;
    logic        front;
    logic        sdone;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int r, input int sq, input int sa, input int wv, input int wa,
                              input int wd, input int sw, input int fe, input int rdy, input int we,
                              input int ad, input int ewd, input int sv, input int sd, input int fr,
                              input int dn, input int er);
    vec_t v;
    v.rst = 1'(r);     v.sreq = 1'(sq);    v.saddr = 11'(sa);
    v.wv = 1'(wv);     v.waddr = 11'(wa);  v.wdata = 24'(wd);
    v.swreq = 1'(sw);  v.fe = 1'(fe);
    v.ready = 1'(rdy); v.we = 1'(we);      v.addr = 12'(ad);
    v.ewdata = 24'(ewd); v.svalid = 1'(sv); v.sdata = 24'(sd);
    v.front = 1'(fr);  v.sdone = 1'(dn);   v.err = 1'(er);
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    rst           = v.rst;
    bus.scan_req  = v.sreq;
    bus.scan_addr = v.saddr;
    bus.wr_valid  = v.wv;
    bus.wr_addr   = v.waddr;
    bus.wr_data   = v.wdata;
    bus.swap_req  = v.swreq;
    bus.frame_end = v.fe;
    #1;
    check({p, " wr_ready"},   32'(bus.wr_ready),   32'(v.ready));
    check({p, " mem_we"},     32'(bus.mem_we),     32'(v.we));
    check({p, " mem_addr"},   32'(bus.mem_addr),   32'(v.addr));
    check({p, " scan_valid"}, 32'(bus.scan_valid), 32'(v.svalid));
    check({p, " front_bank"}, 32'(bus.front_bank), 32'(v.front));
    check({p, " swap_done"},  32'(bus.swap_done),  32'(v.sdone));
    check({p, " starve_err"}, 32'(bus.starve_err), 32'(v.err));
    if (v.we) check({p, " mem_wdata"}, 32'(bus.mem_wdata), 32'(v.ewdata));
    if (v.svalid) check({p, " scan_data"}, 32'(bus.scan_data), 32'(v.sdata));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int drn;

    bus.scan_req = 1'b0; bus.scan_addr = '0; bus.frame_end = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_addr = 11'h001; bus.wr_data = 24'h0;
    bus.swap_req = 1'b0;

    // Reset held for two edges with a write offered; preload the scan word.
    rst = 1'b0; pl_we = 1'b1; pl_addr = 12'h005; pl_data = 24'hABC123;
    #1;
    check("rst0 wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst0 mem_we",   32'(bus.mem_we),   32'd0);
    @(negedge clk);
    pl_we = 1'b0;
    #1;
    check("rst1 wr_ready",   32'(bus.wr_ready),   32'd0);
    check("rst1 mem_we",     32'(bus.mem_we),     32'd0);
    check("rst1 front_bank", 32'(bus.front_bank), 32'd0);
    check("rst1 starve_err", 32'(bus.starve_err), 32'd0);
    check("rst1 scan_valid", 32'(bus.scan_valid), 32'd0);
    check("rst1 swap_done",  32'(bus.swap_done),  32'd0);

    //           rst sq sa     wv wa     wd        sw fe | rdy we addr   ewd       sv sd         fr dn er
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0,  1, 0, 'h000, 0,        0, 0,         0, 0, 0));
    tbl.push_back(mk(1, 1, 5,     0, 0,     0,        0, 0,  1, 0, 'h005, 0,        0, 0,         0, 0, 0));
    tbl.push_back(mk(1, 0, 0,     1, 7,     'h111222, 0, 0,  1, 0, 'h000, 0,        1, 'hABC123,  0, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0,  0, 1, 'h807, 'h111222, 0, 0,         0, 0, 0));
    tbl.push_back(mk(1, 0, 0,     1, 'h010, 'h0000AA, 0, 0,  1, 0, 'h000, 0,        0, 0,         0, 0, 0));
    // Conflict: three scans hold off the drain.
    tbl.push_back(mk(1, 1, 'h020, 0, 0,     0,        0, 0,  0, 0, 'h020, 0,        0, 0,         0, 0, 0));
    tbl.push_back(mk(1, 1, 'h020, 0, 0,     0,        0, 0,  0, 0, 'h020, 0,        1, 0,         0, 0, 0));
    tbl.push_back(mk(1, 1, 'h021, 0, 0,     0,        0, 0,  0, 0, 'h021, 0,        1, 0,         0, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0,  0, 1, 'h810, 'h0000AA, 1, 0,         0, 0, 0));
    // Starvation: eight blocked cycles raise the sticky error.
    tbl.push_back(mk(1, 0, 0,     1, 'h033, 'h333333, 0, 0,  1, 0, 'h000, 0,        0, 0,         0, 0, 0));
    tbl.push_back(mk(1, 1, 2,     0, 0,     0,        0, 0,  0, 0, 'h002, 0,        0, 0,         0, 0, 0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(1, 1, 2,   0, 0,     0,        0, 0,  0, 0, 'h002, 0,        1, 0,         0, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0,  0, 1, 'h833, 'h333333, 1, 0,         0, 0, 1));
    // Swap with a write still buffered at the first frame end.
    tbl.push_back(mk(1, 0, 0,     1, 'h044, 'h444444, 0, 0,  1, 0, 'h000, 0,        0, 0,         0, 0, 1));
    tbl.push_back(mk(1, 1, 3,     0, 0,     0,        1, 0,  0, 0, 'h003, 0,        0, 0,         0, 0, 1));
    tbl.push_back(mk(1, 1, 3,     0, 0,     0,        0, 1,  0, 0, 'h003, 0,        1, 0,         0, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0,  0, 1, 'h844, 'h444444, 1, 0,         0, 0, 1));
    tbl.push_back(mk(1, 0, 0,     1, 'h055, 'h555555, 0, 0,  0, 0, 'h000, 0,        0, 0,         0, 0, 1));
    tbl.push_back(mk(1, 1, 7,     1, 'h055, 'h555555, 0, 1,  0, 0, 'h007, 0,        0, 0,         0, 0, 1));
    tbl.push_back(mk(1, 1, 7,     0, 0,     0,        0, 0,  1, 0, 'h807, 0,        1, 0,         1, 1, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0,  1, 0, 'h800, 0,        1, 'h111222,  1, 0, 1));
    // swap_req with frame_end in RUN only arms; a second swap_req in PEND is dropped.
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        1, 1,  1, 0, 'h800, 0,        0, 0,         1, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0,  0, 0, 'h800, 0,        0, 0,         1, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        1, 0,  0, 0, 'h800, 0,        0, 0,         1, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 1,  0, 0, 'h800, 0,        0, 0,         1, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0,  1, 0, 'h000, 0,        0, 0,         0, 1, 1));
    // Reset while a write is buffered and a swap is pending.
    tbl.push_back(mk(1, 0, 0,     1, 'h066, 'h666666, 0, 0,  1, 0, 'h000, 0,        0, 0,         0, 0, 1));
    tbl.push_back(mk(1, 1, 0,     0, 0,     0,        1, 0,  0, 0, 'h000, 0,        0, 0,         0, 0, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0,     0,        0, 0,  0, 0, 'h000, 0,        1, 0,         0, 0, 1));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0,  1, 0, 'h000, 0,        0, 0,         0, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 1,  1, 0, 'h000, 0,        0, 0,         0, 0, 0));
    tbl.push_back(mk(1, 0, 0,     0, 0,     0,        0, 0,  1, 0, 'h000, 0,        0, 0,         0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    check("discarded write bank1", 32'(ram[12'h866]), 32'd0);
    check("discarded write bank0", 32'(ram[12'h066]), 32'd0);
    check("swapped write landed",  32'(ram[12'h807]), 32'h111222);

    // Back-to-back offers: at most one write every two cycles.
    acc = 0;
    drn = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.scan_req = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 11'(12'h100 + k);
      bus.wr_data  = 24'(24'hD00000 + k);
      #1;
      if (bus.wr_valid && bus.wr_ready) acc++;
      if (bus.mem_we) drn++;
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    check("burst accepts", 32'(acc), 32'd4);
    check("burst drains",  32'(drn), 32'd4);
    check("burst last word", 32'(ram[12'h906]), 32'hD00006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
